voice_mixer: RTL
================

Name: voice_mixer

Overview:
- Downstream stage of the voice bank; replaces the flat combinational sum of the 8 voice outputs.
- Sums all voice outputs with a per-voice enable mask, applies an 8-bit master gain and saturates to 16 bits.
- Drives the LDATA/RDATA sample into audio_interface, once per rising AUD_DACLRCK edge.
- Runs on CLOCK_50 and resolves the AUD_DACLRCK domain crossing internally.

Parameters:
- NUM_VOICES, 8, number of voice inputs summed.
- SAMPLE_W, 16, signed width of each voice sample and of the output.
- GAIN_W, 8, unsigned master gain width.
- GAIN_SHIFT, 7, right shift applied after the gain multiply (128 = unity).

Ports:
- Clk  input  1  system clock (CLOCK_50).
- Reset  input  1  asynchronous reset, active-high.
- lrck_in  input  1  AUD_DACLRCK; asynchronous to Clk.
- voice_in  input  NUM_VOICES*SAMPLE_W  packed signed voice samples; voice k occupies bits [k*16+15:k*16].
- voice_mask  input  NUM_VOICES  bit k=1 includes voice k in the sum.
- master_gain  input  GAIN_W  unsigned gain.
- clip_clr  input  1  clears the sticky clip and overrun flags.
- out_sample  output  SAMPLE_W  mixed signed sample (drives LDATA/RDATA).
- sample_valid  output  1  one-Clk pulse when out_sample updates.
- clip  output  1  sticky; set when saturation occurs.
- overrun  output  1  sticky; set when an lrck edge arrives while busy.
- busy  output  1  high while the FSM is not IDLE.

Behaviour:
- Interface: one clock, Clk; Reset asynchronous, active-high.
- Reset values: out_sample=0, sample_valid=0, clip=0, overrun=0, busy=0; FSM=IDLE; accumulator, index and snapshot registers = 0; synchronizer flops = 0.
- lrck synchronizer: s1<=lrck_in, s2<=s1, s3<=s2. edge = s2 & ~s3.
- The cycle in which edge=1 is cycle E.
- IDLE, edge=1 at cycle E: snapshot voice_in, voice_mask and master_gain; acc<=0; idx<=0; state<=ACCUM.
- ACCUM, cycles E+1..E+8: if mask_snap[idx], acc += sign-extended snap[idx]. acc is 19 bits signed, so it cannot overflow. idx increments each cycle. After idx=NUM_VOICES-1, state<=SCALE.
- SCALE, cycle E+9: prod = acc * {1'b0,gain_snap}, 28-bit signed. scaled = prod >>> GAIN_SHIFT (arithmetic shift, floor rounding). state<=SAT.
- SAT, cycle E+10: if scaled > 32767, out_sample<=0x7FFF and clip<=1. If scaled < -32768, out_sample<=0x8000 and clip<=1. Otherwise out_sample<=scaled[15:0]. sample_valid<=1 for exactly one cycle; state<=IDLE.
- Latency: edge cycle to sample_valid high is 11 Clk cycles.
- out_sample holds its value between updates.
- edge while state != IDLE: the edge is ignored, overrun<=1, and the in-progress computation completes unaffected.
- clip_clr=1 clears clip and overrun. If a set event occurs in the same cycle, set wins.
- busy = (state != IDLE).
- Inputs that change after the snapshot have no effect on the current sample.
- voice_mask=0: the result is 0 and sample_valid still pulses.
- master_gain=0: the result is 0 and clip is not set.
- Reset asserted mid-operation: immediate return to reset values; no sample_valid pulse for the aborted sample.

Decomposition:
- synth_pkg holds:
  - constants NUM_VOICES, SAMPLE_W, GAIN_W, GAIN_SHIFT;
  - typedef logic signed [SAMPLE_W-1:0] sample_t;
  - enum mix_state_t {IDLE, ACCUM, SCALE, SAT};
  - function sat16(), which saturates a signed value to sample_t.
- One sub-module: lrck_edge_sync, containing the 3-flop synchronizer plus rising-edge detect. It has ports Clk, Reset, async_in, rise.

Test Plan:
1. All voices 0x0400, mask 0xFF, gain 128, one lrck rise -> sample_valid exactly 11 cycles after edge; out_sample=0x2000; clip=0.
2. All voices 0x1000, mask 0xFF, gain 128 -> out_sample=0x7FFF, clip=1. Then clip_clr pulse -> clip=0.
3. All voices 0x1000, gain 64 -> 0x4000. Same voices with mask 0x0F, gain 128 -> 0x4000. All voices 0xC000 (-16384), gain 128 -> 0x8000 with clip=1.
4. Voices alternating +1000/-1000, gain 255 -> out_sample=0. Voice0=-3 only, gain 64 -> out_sample=0xFFFE (floor of -1.5).
5. Second lrck rise 5 Clk cycles after the first edge -> only one sample_valid pulse, overrun=1, out_sample equals the first sample's result.
6. Reset asserted during ACCUM (cycle E+4) -> all outputs 0 immediately, busy=0, no sample_valid. The next lrck rise after reset release produces a correct sample.

Source files
------------

// File: rtl/synth_pkg.sv
// ============================================================================
// Module   : synth_pkg
// Brief    : Shared constants, types and saturation helper for the voice mixer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package synth_pkg;

  localparam int NUM_VOICES = 8;
  localparam int SAMPLE_W   = 16;
  localparam int GAIN_W     = 8;
  localparam int GAIN_SHIFT = 7;

  // Accumulator grows by log2(NUM_VOICES) bits so the voice sum never overflows.
  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int ACC_W  = SAMPLE_W + IDX_W;
  localparam int PROD_W = ACC_W + GAIN_W + 1;

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 <<< (SAMPLE_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(1 <<< (SAMPLE_W - 1)));

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    SAT   = 2'd3
  } mix_state_t;

  function automatic sample_t sat16(input logic signed [PROD_W-1:0] val);
    sample_t res;
    if (val > SAT_MAX) begin
      res = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (val < SAT_MIN) begin
      res = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      res = val[SAMPLE_W-1:0];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lrck_edge_sync.sv
// ============================================================================
// Module   : lrck_edge_sync
// Brief    : Three-flop synchronizer for an asynchronous strobe plus rising-edge detect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lrck_edge_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= async_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s1 may be metastable; the edge is taken only from settled stages.
  assign rise = r_s2 & ~r_s3;

endmodule

`default_nettype wire

// File: rtl/voice_mixer.sv
// ============================================================================
// Module   : voice_mixer
// Brief    : Masked sum of the voice bank, master gain and 16-bit saturation,
//            one sample per rising DAC LR clock edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_mixer
  import synth_pkg::*;
(
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           lrck_in,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
  input  logic [NUM_VOICES-1:0]          voice_mask,
  input  logic [GAIN_W-1:0]              master_gain,
  input  logic                           clip_clr,
  output logic [SAMPLE_W-1:0]            out_sample,
  output logic                           sample_valid,
  output logic                           clip,
  output logic                           overrun,
  output logic                           busy
);

  mix_state_t                r_state;
  mix_state_t                w_state_nxt;
  logic                      w_edge;
  logic                      w_last;
  logic                      w_clip_set;
  logic                      w_overrun_set;
  sample_t                   r_snap [NUM_VOICES];
  logic [NUM_VOICES-1:0]     r_mask_snap;
  logic [GAIN_W-1:0]         r_gain_snap;
  logic [IDX_W-1:0]          r_idx;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [PROD_W-1:0]  w_scaled;
  logic signed [PROD_W-1:0]  r_scaled;

  lrck_edge_sync u_lrck_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (lrck_in),
    .rise     (w_edge)
  );

  assign w_last        = (r_idx == IDX_W'(NUM_VOICES - 1));
  assign busy          = (r_state != IDLE);
  assign w_overrun_set = w_edge && (r_state != IDLE);
  assign w_clip_set    = (r_state == SAT) && ((r_scaled > SAT_MAX) || (r_scaled < SAT_MIN));

  // Gain is zero-extended so it multiplies as a non-negative signed operand.
  assign w_prod   = PROD_W'(r_acc) * PROD_W'($signed({1'b0, r_gain_snap}));
  assign w_scaled = w_prod >>> GAIN_SHIFT;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_edge) w_state_nxt = ACCUM;
      ACCUM:   if (w_last) w_state_nxt = SCALE;
      SCALE:   w_state_nxt = SAT;
      SAT:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        r_snap[k] <= '0;
      end
      r_mask_snap  <= '0;
      r_gain_snap  <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_scaled     <= '0;
      out_sample   <= '0;
      sample_valid <= 1'b0;
      clip         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
              r_snap[k] <= voice_in[k*SAMPLE_W +: SAMPLE_W];
            end
            r_mask_snap <= voice_mask;
            r_gain_snap <= master_gain;
            r_acc       <= '0;
            r_idx       <= '0;
          end
        end
        ACCUM: begin
          if (r_mask_snap[r_idx]) begin
            r_acc <= r_acc + ACC_W'(r_snap[r_idx]);
          end
          r_idx <= r_idx + 1'b1;
        end
        SCALE: r_scaled <= w_scaled;
        SAT: begin
          out_sample   <= sat16(r_scaled);
          sample_valid <= 1'b1;
        end
        default: ;
      endcase

      // Set events take priority over a simultaneous clear.
      if (w_clip_set) begin
        clip <= 1'b1;
      end else if (clip_clr) begin
        clip <= 1'b0;
      end

      if (w_overrun_set) begin
        overrun <= 1'b1;
      end else if (clip_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
